// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//   Parametrised serial pattern detector. It compares a valid-qualified 1-bit
//   stream against a compile-time pattern and produces a registered one-cycle
//   pulse on every match. Overlapping or non-overlapping detection is chosen
//   at run time.
//
// Parameters
//   LEN      pattern length in bits (2..32)
//   PATTERN  pattern bits; the MSB is the first bit received. Only the low LEN
//            bits may be set.
//   CNT_W    width of match_count (1..32)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          asynchronous reset, active low
//   in           serial data bit, sampled when in_valid=1
//   in_valid     qualifies in; idle cycles leave detection state untouched
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   clear        synchronous flush of history, fill, count and detected
//   detected     registered one-cycle match pulse
//   match_count  saturating count of matches since reset or clear
//   fill         number of history bits currently contributing to a match
//
// Build option
//   SEQDET_COUNT_EN  when defined, builds the saturating match counter.
//                    When undefined, match_count is tied to zero.
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int          LEN     = 4,
  parameter logic [31:0] PATTERN = 32'b1011,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             clear,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic [5:0]       fill
);

  // Elaboration-time parameter checks
  if (LEN < 2 || LEN > 32) begin : g_len_chk
    $error("seq_detect_param: LEN=%0d out of range 2..32", LEN);
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_chk
    $error("seq_detect_param: CNT_W=%0d out of range 1..32", CNT_W);
  end
  if (LEN < 32 && (PATTERN >> LEN) != 32'd0) begin : g_pat_chk
    $error("seq_detect_param: PATTERN wider than LEN=%0d", LEN);
  end

  localparam logic [5:0]     FILL_MAX = 6'(LEN - 1);
  localparam logic [LEN-1:0] PAT      = PATTERN[LEN-1:0];

  logic [LEN-2:0] hist;
  logic [5:0]     fill_q;
  logic [LEN-1:0] window;
  logic           accept;
  logic           match;

  assign window = {hist, in};
  assign accept = in_valid && !clear;
  // The window is only meaningful once LEN-1 earlier bits have been taken.
  assign match  = accept && (fill_q == FILL_MAX) && (window == PAT);
  assign fill   = fill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist     <= '0;
      fill_q   <= '0;
      detected <= 1'b0;
    end else if (clear) begin
      hist     <= '0;
      fill_q   <= '0;
      detected <= 1'b0;
    end else begin
      detected <= match;
      if (accept) begin
        // After a non-overlap match the history is don't-care, because fill
        // restarts at zero. Shifting unconditionally keeps the datapath simple.
        hist <= window[LEN-2:0];
        if (match && !overlap)
          fill_q <= '0;
        else if (fill_q != FILL_MAX)
          fill_q <= fill_q + 6'd1;
      end
    end
  end

`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      match_count <= '0;
    else if (clear)
      match_count <= '0;
    else if (match && (match_count != {CNT_W{1'b1}}))
      match_count <= match_count + 1'b1;
  end
`else
  assign match_count = '0;
`endif

endmodule
